// File: rtl/axi_idunq_tracker.sv
// AXI unique-ID tracker: per-ID outstanding counts and unique flags for the
// write (AW/B) and read (AR/R) pairs, with violation pulses and sticky status.

module axi_idunq_dir #(
  parameter int ID_WIDTH  = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          req_fire,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic                          req_unq,
  input  logic                          cmp_fire,
  input  logic [ID_WIDTH-1:0]           cmp_id,
  input  logic                          cmp_unq,
  output logic                          allow,
  output logic [2:0]                    err_next,
  output logic [ID_WIDTH+CNT_WIDTH-1:0] outstanding
);

  localparam int N  = 1 << ID_WIDTH;
  localparam int OW = ID_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [CNT_WIDTH-1:0] cnt [N];
  logic [N-1:0]         uflag;
  logic [CNT_WIDTH-1:0] cmp_cnt;
  logic [CNT_WIDTH-1:0] ecnt;
  logic                 cmp_ok;
  logic                 credit;
  logic                 ovf;
  logic                 uniq_err;
  logic                 req_cnt;

  // A same-cycle completion on the requested ID frees one slot before the request is judged.
  always_comb begin
    cmp_cnt  = cnt[cmp_id];
    cmp_ok   = cmp_fire && (cmp_cnt != '0);
    credit   = cmp_ok && (cmp_id == req_id);
    ecnt     = cnt[req_id] - CNT_WIDTH'(credit);
    ovf      = (ecnt == CMAX);
    uniq_err = (ecnt != '0) && (req_unq || uflag[req_id]);
    allow    = !ovf && !uniq_err;
    req_cnt  = req_fire && !ovf;
    err_next = {cmp_fire && ((cmp_cnt == '0) || (cmp_unq != uflag[cmp_id])),
                req_fire && ovf,
                req_fire && uniq_err};
  end

  // Request update is written last so it wins when it targets the completing ID.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      uflag       <= '0;
      outstanding <= '0;
    end else begin
      if (cmp_ok) begin
        cnt[cmp_id] <= cmp_cnt - CNT_WIDTH'(1);
        if (cmp_cnt == CNT_WIDTH'(1)) uflag[cmp_id] <= 1'b0;
      end
      if (req_cnt) begin
        cnt[req_id]   <= ecnt + CNT_WIDTH'(1);
        uflag[req_id] <= req_unq;
      end
      outstanding <= outstanding + OW'(req_cnt) - OW'(cmp_ok);
    end
  end

endmodule

module axi_idunq_tracker #(
  parameter int ID_W_WIDTH    = 4,
  parameter int ID_R_WIDTH    = 4,
  parameter int CNT_WIDTH     = 4,
  parameter int RLAST_Present = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            awvalid,
  input  logic                            awready,
  input  logic                            awidunq,
  input  logic [ID_W_WIDTH-1:0]           awid,
  input  logic                            bvalid,
  input  logic                            bready,
  input  logic                            bidunq,
  input  logic [ID_W_WIDTH-1:0]           bid,
  input  logic                            arvalid,
  input  logic                            arready,
  input  logic                            aridunq,
  input  logic [ID_R_WIDTH-1:0]           arid,
  input  logic                            rvalid,
  input  logic                            rready,
  input  logic                            rlast,
  input  logic                            ridunq,
  input  logic [ID_R_WIDTH-1:0]           rid,
  input  logic                            err_clear,
  output logic                            aw_allow,
  output logic                            ar_allow,
  output logic [5:0]                      err_pulse,
  output logic [5:0]                      err_status,
  output logic [ID_W_WIDTH+CNT_WIDTH-1:0] w_outstanding,
  output logic [ID_R_WIDTH+CNT_WIDTH-1:0] r_outstanding
);

  logic [2:0] w_err;
  logic [2:0] r_err;
  logic [5:0] err_next;
  logic       r_cmp;

  // Without RLAST every read beat is a whole transaction.
  assign r_cmp    = rvalid && rready && (rlast || (RLAST_Present == 0));
  assign err_next = {r_err, w_err};

  axi_idunq_dir #(.ID_WIDTH(ID_W_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_w (
    .aclk        (aclk),
    .areset      (areset),
    .req_fire    (awvalid && awready),
    .req_id      (awid),
    .req_unq     (awidunq),
    .cmp_fire    (bvalid && bready),
    .cmp_id      (bid),
    .cmp_unq     (bidunq),
    .allow       (aw_allow),
    .err_next    (w_err),
    .outstanding (w_outstanding)
  );

  axi_idunq_dir #(.ID_WIDTH(ID_R_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_r (
    .aclk        (aclk),
    .areset      (areset),
    .req_fire    (arvalid && arready),
    .req_id      (arid),
    .req_unq     (aridunq),
    .cmp_fire    (r_cmp),
    .cmp_id      (rid),
    .cmp_unq     (ridunq),
    .allow       (ar_allow),
    .err_next    (r_err),
    .outstanding (r_outstanding)
  );

  // A new error in the clearing cycle keeps its status bit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_pulse  <= '0;
      err_status <= '0;
    end else begin
      err_pulse  <= err_next;
      err_status <= (err_clear ? 6'd0 : err_status) | err_next;
    end
  end

endmodule
